// File: rtl/systolic_tile_engine.sv
// Output-stationary ROWS x COLS BF16 systolic tile: skewed operand feed, FP32 accumulators, row-serial readout.
// Optional SA_PERF_CNT_EN adds a perf_cycles output counting busy cycles per tile.
module systolic_tile_engine #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int K_MAX = 256
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [ROWS*16-1:0]                        in_a,
  input  logic [COLS*16-1:0]                        in_b,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [COLS*32-1:0]                        out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                                      out_last,
  output logic                                      k_overflow
`ifdef SA_PERF_CNT_EN
  ,
  output logic [31:0]                               perf_cycles
`endif
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = $clog2(K_MAX + 1);
  localparam int FW = $clog2(ROWS + COLS + 1);
  localparam int SR = (ROWS > 1) ? ROWS - 1 : 1;
  localparam int SC = (COLS > 1) ? COLS - 1 : 1;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, OUT} state_t;

  // Valid/ready: a beat moves on in_valid && in_ready, a row on out_valid && out_ready;
  // the presented row (data, index, last) holds while out_valid && !out_ready.
  state_t              state;
  logic [KW-1:0]       kcnt;
  logic [FW-1:0]       fcnt;
  logic                fire;
  logic                clear;
  logic [RW-1:0]       nxt_row;
  // Operands are {tag, bf16}; tag 0 marks a bubble that must not accumulate.
  logic [16:0]         a_sk [ROWS][SR];
  logic [16:0]         b_sk [COLS][SC];
  logic [16:0]         a_feed [ROWS];
  logic [16:0]         b_feed [COLS];
  logic [16:0]         ar [ROWS][COLS];
  logic [16:0]         br [ROWS][COLS];
  logic [31:0]         acc [ROWS][COLS];
  logic [COLS*32-1:0]  row_data [ROWS];

  function automatic logic [31:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [15:0] p;
    logic [22:0] frac;
    int          e;
    s  = a[15] ^ b[15];
    ea = a[14:7];
    eb = b[14:7];
    if ((ea == 8'hFF && a[6:0] != 7'h0) || (eb == 8'hFF && b[6:0] != 7'h0)) return 32'h7FC00000;
    if (ea == 8'hFF || eb == 8'hFF) return (ea == 8'h0 || eb == 8'h0) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
    if (ea == 8'h0 || eb == 8'h0) return {s, 31'h0};
    p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
    e = int'(ea) + int'(eb) - 127;
    if (p[15]) begin
      e++;
      frac = {p[14:0], 8'h0};
    end else begin
      frac = {p[13:0], 9'h0};
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], frac};
  endfunction

  // Round-to-nearest-even FP32 add; subnormals flush to zero.
  function automatic logic [31:0] fp32_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [26:0] ma, mb;
    logic [27:0] s;
    logic [23:0] m;
    logic        xn, yn, xi, yi, g, st;
    int          e, d;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
    if (xn || yn || (xi && yi && x[31] != y[31])) return 32'h7FC00000;
    if (xi) return x;
    if (yi) return y;
    if (x[30:0] >= y[30:0]) begin a = x; b = y; end
    else begin a = y; b = x; end
    ma = (a[30:23] == 8'h0) ? 27'h0 : {1'b1, a[22:0], 3'b0};
    mb = (b[30:23] == 8'h0) ? 27'h0 : {1'b1, b[22:0], 3'b0};
    d  = int'(a[30:23]) - int'(b[30:23]);
    if (d > 26) begin
      st = |mb;
      mb = '0;
      mb[0] = st;
    end else if (d > 0) begin
      st = |(mb & ((27'd1 << d) - 27'd1));
      mb = mb >> d;
      mb[0] = mb[0] | st;
    end
    e = int'(a[30:23]);
    s = (a[31] == b[31]) ? ({1'b0, ma} + {1'b0, mb}) : ({1'b0, ma} - {1'b0, mb});
    if (s == '0) return 32'h0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e++;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!s[26]) begin
          s = s << 1;
          e--;
        end
      end
    end
    m  = s[26:3];
    g  = s[2];
    st = s[1] | s[0];
    if (g && (st || m[0])) begin
      m = m + 24'd1;
      if (m == 24'h0) begin
        m = 24'h800000;
        e++;
      end
    end
    if (e >= 255) return {a[31], 8'hFF, 23'h0};
    if (e <= 0) return {a[31], 31'h0};
    return {a[31], e[7:0], m[22:0]};
  endfunction

  assign in_ready = (state == IDLE) || (state == FEED);
  assign fire     = in_valid && in_ready;
  assign clear    = out_valid && out_ready && out_last;
  assign nxt_row  = out_row + RW'(1);

  always_comb begin
    for (int i = 0; i < ROWS; i++) a_feed[i] = (i == 0) ? {fire, in_a[15:0]} : a_sk[i][(i == 0) ? 0 : i - 1];
    for (int j = 0; j < COLS; j++) b_feed[j] = (j == 0) ? {fire, in_b[15:0]} : b_sk[j][(j == 0) ? 0 : j - 1];
    for (int i = 0; i < ROWS; i++) begin
      row_data[i] = '0;
      for (int j = 0; j < COLS; j++) row_data[i][32*j +: 32] = acc[i][j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      kcnt       <= '0;
      fcnt       <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_last   <= 1'b0;
      out_data   <= '0;
      k_overflow <= 1'b0;
      for (int i = 0; i < ROWS; i++) for (int d = 0; d < SR; d++) a_sk[i][d] <= '0;
      for (int j = 0; j < COLS; j++) for (int d = 0; d < SC; d++) b_sk[j][d] <= '0;
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
          acc[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        a_sk[i][0] <= {fire, in_a[16*i +: 16]};
        for (int d = 1; d < SR; d++) a_sk[i][d] <= a_sk[i][d-1];
      end
      for (int j = 0; j < COLS; j++) begin
        b_sk[j][0] <= {fire, in_b[16*j +: 16]};
        for (int d = 1; d < SC; d++) b_sk[j][d] <= b_sk[j][d-1];
      end
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          ar[i][j] <= (j == 0) ? a_feed[i] : ar[i][(j == 0) ? 0 : j - 1];
          br[i][j] <= (i == 0) ? b_feed[j] : br[(i == 0) ? 0 : i - 1][j];
          if (clear) acc[i][j] <= '0;
          else if (ar[i][j][16] && br[i][j][16])
            acc[i][j] <= fp32_add(acc[i][j], bf16_mul(ar[i][j][15:0], br[i][j][15:0]));
        end
      end

      case (state)
        IDLE: if (fire) begin
          kcnt       <= KW'(1);
          k_overflow <= 1'b0;
          if (in_last || K_MAX == 1) begin
            state      <= FLUSH;
            fcnt       <= FW'(ROWS + COLS);
            k_overflow <= !in_last;
          end else begin
            state <= FEED;
          end
        end
        FEED: if (fire) begin
          kcnt <= kcnt + KW'(1);
          if (in_last || (kcnt + KW'(1) == KW'(K_MAX))) begin
            state <= FLUSH;
            fcnt  <= FW'(ROWS + COLS);
            if (!in_last) k_overflow <= 1'b1;
          end
        end
        FLUSH: begin
          fcnt <= fcnt - FW'(1);
          if (fcnt == FW'(1)) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_row   <= '0;
            out_last  <= (ROWS == 1);
            out_data  <= row_data[0];
          end
        end
        OUT: if (out_valid && out_ready) begin
          if (out_last) begin
            state     <= IDLE;
            kcnt      <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
            out_data  <= '0;
          end else begin
            out_row  <= nxt_row;
            out_last <= (nxt_row == RW'(ROWS - 1));
            out_data <= row_data[nxt_row];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SA_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cycles <= '0;
    else if (state == IDLE && fire) perf_cycles <= 32'd1;
    else if (state != IDLE && perf_cycles != 32'hFFFFFFFF) perf_cycles <= perf_cycles + 32'd1;
  end
`endif
endmodule
